// File: rtl/pipelined_sklansky_subtractor.sv
// Two-stage 16-bit subtractor: A - B - bin computed as A + ~B + ~bin
// on a radix-2 Sklansky prefix network, split two levels per stage.
module pipelined_sklansky_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_bout,
    output logic             out_zero,
    output logic             out_ovf
);

    logic             s2_adv;
    logic             s1_adv;

    logic [WIDTH-1:0] g0, p0, g1, p1, g2_d, p2_d;
    logic             c0_d;

    logic             s1_valid_q;
    logic [WIDTH-1:0] g2_q, p2_q, pr_q;
    logic             c0_q, a15_q, b15_q;

    logic [WIDTH-1:0] g3, p3, g4, p4;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d, zero_d, ovf_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_diff_q;
    logic             out_bout_q, out_zero_q, out_ovf_q;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & rst_n;

    assign c0_d = ~in_bin;
    assign g0   = in_a & ~in_b;
    assign p0   = in_a ^ ~in_b;

    // Levels 1-2: odd bits pair with i-1, bit-1-set bits with bit 1 of their block
    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl12
        if ((i & 1) == 1) begin : g_l1c
            assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
            assign p1[i] = p0[i] & p0[i-1];
        end else begin : g_l1p
            assign g1[i] = g0[i];
            assign p1[i] = p0[i];
        end
        if (((i >> 1) & 1) == 1) begin : g_l2c
            assign g2_d[i] = g1[i] | (p1[i] & g1[((i >> 1) << 1) - 1]);
            assign p2_d[i] = p1[i] & p1[((i >> 1) << 1) - 1];
        end else begin : g_l2p
            assign g2_d[i] = g1[i];
            assign p2_d[i] = p1[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            g2_q       <= '0;
            p2_q       <= '0;
            pr_q       <= '0;
            c0_q       <= 1'b0;
            a15_q      <= 1'b0;
            b15_q      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                g2_q  <= g2_d;
                p2_q  <= p2_d;
                pr_q  <= p0;
                c0_q  <= c0_d;
                a15_q <= in_a[WIDTH-1];
                b15_q <= in_b[WIDTH-1];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lvl34
        if (((i >> 2) & 1) == 1) begin : g_l3c
            assign g3[i] = g2_q[i] | (p2_q[i] & g2_q[((i >> 2) << 2) - 1]);
            assign p3[i] = p2_q[i] & p2_q[((i >> 2) << 2) - 1];
        end else begin : g_l3p
            assign g3[i] = g2_q[i];
            assign p3[i] = p2_q[i];
        end
        if (((i >> 3) & 1) == 1) begin : g_l4c
            assign g4[i] = g3[i] | (p3[i] & g3[((i >> 3) << 3) - 1]);
            assign p4[i] = p3[i] & p3[((i >> 3) << 3) - 1];
        end else begin : g_l4p
            assign g4[i] = g3[i];
            assign p4[i] = p3[i];
        end
        // Carry-in folds into every prefix, not just bit 0
        assign c[i+1] = g4[i] | (p4[i] & c0_q);
    end

    assign c[0]   = c0_q;
    assign diff_d = pr_q ^ c[WIDTH-1:0];
    assign bout_d = ~c[WIDTH];
    assign zero_d = ~|diff_d;
    assign ovf_d  = (a15_q != b15_q) & (diff_d[WIDTH-1] != a15_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_diff_q  <= '0;
            out_bout_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_diff_q <= diff_d;
                out_bout_q <= bout_d;
                out_zero_q <= zero_d;
                out_ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_diff  = out_diff_q;
    assign out_bout  = out_bout_q;
    assign out_zero  = out_zero_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_sklansky_subtractor.sv
// Directed and randomised checks of the pipelined Sklansky subtractor
// against an arithmetic reference model.
module tb_pipelined_sklansky_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_diff;
    logic        out_bout;
    logic        out_zero;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    pipelined_sklansky_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff),
        .out_bout  (out_bout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {ovf, zero, bout, diff} from plain integer arithmetic
    function automatic logic [18:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic bin);
        int          d;
        int          sd;
        logic [15:0] r;
        d  = int'(a) - int'(b) - int'(bin);
        sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
        r  = d[15:0];
        return {(sd < -32768 || sd > 32767), (r == 16'h0), (d < 0), r};
    endfunction

    function automatic logic [18:0] outs();
        return {out_ovf, out_zero, out_bout, out_diff};
    endfunction

    // Present one operand set to an empty pipeline, check 2-edge latency
    task automatic one(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic bin,
                       input logic [18:0] exp);
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_bin    = bin;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, {13'd0, outs()}, {13'd0, exp});
    endtask

    logic [18:0] q[$];
    logic [15:0] got[$];
    int          gcyc[$];
    int          kk;
    logic        acc;
    logic [18:0] e;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {13'd0, outs()}, 32'd0);
        chk("rst_ir", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        one("t1", 16'h0005, 16'h0003, 1'b0, {3'b000, 16'h0002});
        one("t2", 16'h0000, 16'h0001, 1'b0, {3'b001, 16'hFFFF});
        one("t3", 16'h8000, 16'h0001, 1'b0, {3'b100, 16'h7FFF});
        one("t4", 16'h7FFF, 16'hFFFF, 1'b0, {3'b101, 16'h8000});
        one("t5", 16'h1234, 16'h1233, 1'b1, {3'b010, 16'h0000});
        one("t6", 16'hFFFF, 16'hFFFF, 1'b1, {3'b001, 16'hFFFF});

        // Stall: 4 back-to-back, out_ready low for 3 cycles
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = 16'h0010;
        in_b      = 16'h0001;
        in_bin    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_b = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        chk("st_ov", {31'd0, out_valid}, 32'd1);
        chk("st_d0", {16'd0, out_diff}, 32'h000F);
        out_ready = 1'b0;
        in_b      = 16'h0003;
        #1;
        chk("st_ir0", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("st_hold_v", {31'd0, out_valid}, 32'd1);
            chk("st_hold_d", {16'd0, out_diff}, 32'h000F);
            chk("st_hold_ir", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        kk        = 3;
        for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got.push_back(out_diff);
                gcyc.push_back(cyc);
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                kk++;
                if (kk > 4) in_valid = 1'b0;
                else in_b = 16'(kk);
            end
        end
        chk("st_cnt", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("st_r1", {16'd0, got[0]}, 32'h000F);
            chk("st_r2", {16'd0, got[1]}, 32'h000E);
            chk("st_r3", {16'd0, got[2]}, 32'h000D);
            chk("st_r4", {16'd0, got[3]}, 32'h000C);
            chk("st_rate", gcyc[3] - gcyc[0], 32'd3);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-stall with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h0100;
        in_b      = 16'h0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rs_full_v", {31'd0, out_valid}, 32'd1);
        chk("rs_full_ir", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_ov", {31'd0, out_valid}, 32'd0);
        chk("rs_out", {13'd0, outs()}, 32'd0);
        chk("rs_ir", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rs_ir2", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'h0009;
        in_b      = 16'h0004;
        in_bin    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs_lat1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rs_v", {31'd0, out_valid}, 32'd1);
        chk("rs_d", {16'd0, out_diff}, 32'h0005);
        @(posedge clk);
        @(negedge clk);
        chk("rs_nostale", {31'd0, out_valid}, 32'd0);

        // Random traffic against the reference queue
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_bin    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rnd", {13'd0, outs()}, {13'd0, e});
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_bin));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("drn_extra", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("drn", {13'd0, outs()}, {13'd0, e});
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("drn_left", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
